// File: rtl/wisc_pkg.sv
// Shared WISC core definitions: opcodes, special encodings and the hazard
// sequencer state type.
package wisc_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_NAND = 4'h2;
   localparam logic [3:0] OP_XOR  = 4'h3;
   localparam logic [3:0] OP_INC  = 4'h4;
   localparam logic [3:0] OP_SRA  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SLL  = 4'h7;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_LHB  = 4'hA;
   localparam logic [3:0] OP_LLB  = 4'hB;
   localparam logic [3:0] OP_B    = 4'hC;
   localparam logic [3:0] OP_CALL = 4'hD;
   localparam logic [3:0] OP_RET  = 4'hE;
   localparam logic [3:0] OP_ERR  = 4'hF;

   localparam logic [15:0] HALT_INSTR = 16'hFFFF;
   localparam logic [3:0]  SP_REG     = 4'd15;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } hz_state_t;

endpackage

// File: rtl/hz_src_decode.sv
// Source-register decode of the instruction in ID. Purely combinational;
// also intended for reuse by the forwarding unit.
module hz_src_decode
   import wisc_pkg::*;
(
   input  logic [15:0] id_instr,
   output logic [3:0]  src_a,
   output logic        src_a_used,
   output logic [3:0]  src_b,
   output logic        src_b_used
);

   // Map opcode to the register fields it actually reads.
   always_comb begin
      src_a      = 4'd0;
      src_a_used = 1'b0;
      src_b      = 4'd0;
      src_b_used = 1'b0;
      case (id_instr[15:12])
         OP_ADD, OP_SUB, OP_NAND, OP_XOR: begin
            src_a      = id_instr[7:4];
            src_a_used = 1'b1;
            src_b      = id_instr[3:0];
            src_b_used = 1'b1;
         end
         OP_INC, OP_SRA, OP_SRL, OP_SLL, OP_LW: begin
            src_a      = id_instr[7:4];
            src_a_used = 1'b1;
         end
         OP_SW: begin
            src_a      = id_instr[7:4];
            src_a_used = 1'b1;
            src_b      = id_instr[11:8];
            src_b_used = 1'b1;
         end
         OP_LHB, OP_LLB: begin
            // Byte loads merge into the existing destination value.
            src_a      = id_instr[11:8];
            src_a_used = 1'b1;
         end
         OP_CALL, OP_RET: begin
            src_a      = SP_REG;
            src_a_used = 1'b1;
         end
         default: begin
            // B and the 1111 group read no registers.
         end
      endcase
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use interlock, redirect flush and HALT drain.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import wisc_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] id_instr,
   input  logic        id_valid,
   input  logic        ex_mem_read,
   input  logic [3:0]  ex_rd,
   input  logic        ex_redirect,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        halted
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   // The redirect/HALT cycle itself is covered by the RUN-state terms, so the
   // counter only needs to cover the remaining N-1 cycles.
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] DRAIN_RELOAD = 3'(DRAIN_CYCLES - 1);

   hz_state_t  state_reg, state_next;
   logic [2:0] cnt_reg, cnt_next;

   logic [3:0] src_a, src_b;
   logic       src_a_used, src_b_used;
   logic       lu;
   logic       is_halt;

   hz_src_decode u_src_decode (
      .id_instr   (id_instr),
      .src_a      (src_a),
      .src_a_used (src_a_used),
      .src_b      (src_b),
      .src_b_used (src_b_used)
   );

   // R0 is hardwired zero, so a load into it never creates a hazard.
   assign lu = id_valid & ex_mem_read & (ex_rd != 4'd0) &
               ((src_a_used & (src_a == ex_rd)) | (src_b_used & (src_b == ex_rd)));
   assign is_halt = id_valid & (id_instr == HALT_INSTR);

   // State and shared FLUSH/DRAIN counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
         cnt_reg   <= 3'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next state plus Moore controls OR'd with RUN-state Mealy terms.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      case (state_reg)
         RUN: begin
            if (ex_redirect) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_next = FLUSH;
                  cnt_next   = FLUSH_RELOAD;
               end
            end else if (lu) begin
               pc_stall    = 1'b1;
               if_id_stall = 1'b1;
               id_ex_flush = 1'b1;
            end else if (is_halt) begin
               pc_stall    = 1'b1;
               if_id_flush = 1'b1;
               if (DRAIN_CYCLES > 1) begin
                  state_next = DRAIN;
                  cnt_next   = DRAIN_RELOAD;
               end else begin
                  state_next = HALTED;
               end
            end
         end
         FLUSH: begin
            // Wrong path: load-use and HALT in ID are irrelevant here.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (ex_redirect) begin
               cnt_next = FLUSH_RELOAD;
            end else if (cnt_reg <= 3'd1) begin
               state_next = RUN;
               cnt_next   = 3'd0;
            end else begin
               cnt_next = cnt_reg - 3'd1;
            end
         end
         DRAIN: begin
            if (ex_redirect) begin
               // An older branch ahead of the HALT wins; the PC must be free
               // to take the redirect, so no PC hold this cycle.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_next = FLUSH;
                  cnt_next   = FLUSH_RELOAD;
               end else begin
                  state_next = RUN;
                  cnt_next   = 3'd0;
               end
            end else begin
               pc_stall    = 1'b1;
               if_id_flush = 1'b1;
               if (cnt_reg <= 3'd1) begin
                  state_next = HALTED;
                  cnt_next   = 3'd0;
               end else begin
                  cnt_next = cnt_reg - 3'd1;
               end
            end
         end
         HALTED: begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         default: begin
            state_next = RUN;
            cnt_next   = 3'd0;
         end
      endcase
      // Keep every control low while reset is held, even with live inputs.
      if (!rst_n) begin
         pc_stall    = 1'b0;
         if_id_stall = 1'b0;
         if_id_flush = 1'b0;
         id_ex_flush = 1'b0;
      end
   end

   assign halted = (state_reg == HALTED);

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt_reg, flush_cnt_reg;
   logic        lu_stall;

   assign lu_stall = (state_reg == RUN) & ~ex_redirect & lu;

   // Saturating event counters, frozen once the core has halted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= 16'd0;
         flush_cnt_reg <= 16'd0;
      end else if (state_reg != HALTED) begin
         if (lu_stall && (stall_cnt_reg != 16'hFFFF))
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
         if ((state_reg == FLUSH) && (flush_cnt_reg != 16'hFFFF))
            flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed plan with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int FC = 2;
   localparam int DC = 3;

   logic        clk;
   logic        rst_n;
   logic [15:0] id_instr;
   logic        id_valid;
   logic        ex_mem_read;
   logic [3:0]  ex_rd;
   logic        ex_redirect;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, halted;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .DRAIN_CYCLES(DC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_instr    (id_instr),
      .id_valid    (id_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .ex_redirect (ex_redirect),
      .pc_stall    (pc_stall),
      .if_id_stall (if_id_stall),
      .if_id_flush (if_id_flush),
      .id_ex_flush (id_ex_flush),
      .halted      (halted)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_pass  = 0;

   // Model state: remaining cycles of each activity rather than an FSM.
   bit m_halted    = 1'b0;
   int m_flush_rem = 0;
   int m_drain_rem = 0;
   int m_scnt      = 0;
   int m_fcnt      = 0;

   function automatic logic [4:0] outs();
      return {pc_stall, if_id_stall, if_id_flush, id_ex_flush, halted};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Set of registers read by an instruction, as a 16-bit membership mask.
   function automatic logic [15:0] used_mask(input logic [15:0] i);
      logic [15:0] m;
      m = 16'd0;
      case (i[15:12])
         4'h0, 4'h1, 4'h2, 4'h3: begin m[i[7:4]] = 1'b1; m[i[3:0]] = 1'b1; end
         4'h4, 4'h5, 4'h6, 4'h7, 4'h8: m[i[7:4]] = 1'b1;
         4'h9: begin m[i[7:4]] = 1'b1; m[i[11:8]] = 1'b1; end
         4'hA, 4'hB: m[i[11:8]] = 1'b1;
         4'hD, 4'hE: m[15] = 1'b1;
         default: m = 16'd0;
      endcase
      return m;
   endfunction

   // Expected {pc_stall,if_id_stall,if_id_flush,id_ex_flush,halted} this cycle,
   // then advance the model across the coming clock edge.
   task automatic model_step(input logic [15:0] instr, input logic v, input logic mr,
                             input logic [3:0] rd, input logic redir, output logic [4:0] e);
      logic [15:0] m;
      logic        hz;
      m  = used_mask(instr);
      hz = v && mr && (rd != 4'd0) && m[rd];
      e  = 5'b00000;
      if (m_halted) begin
         e = 5'b10111;
      end else if (m_drain_rem > 0 && redir) begin
         e = 5'b00110;
         m_drain_rem = 0;
         m_flush_rem = FC - 1;
      end else if (m_drain_rem > 0) begin
         e = 5'b10100;
         m_drain_rem--;
         if (m_drain_rem == 0) m_halted = 1'b1;
      end else if (m_flush_rem > 0) begin
         e = 5'b00110;
         m_fcnt++;
         if (redir) m_flush_rem = FC - 1;
         else       m_flush_rem--;
      end else if (redir) begin
         e = 5'b00110;
         m_flush_rem = FC - 1;
      end else if (hz) begin
         e = 5'b11010;
         m_scnt++;
      end else if (v && instr == 16'hFFFF) begin
         e = 5'b10100;
         m_drain_rem = DC - 1;
         if (m_drain_rem == 0) m_halted = 1'b1;
      end
   endtask

   // One cycle: drive at posedge+1, compare at posedge+3, return at next posedge+1.
   task automatic step(input string name, input logic [15:0] instr, input logic v,
                       input logic mr, input logic [3:0] rd, input logic redir,
                       input logic use_lit, input logic [4:0] lit);
      logic [4:0] e;
      id_instr    = instr;
      id_valid    = v;
      ex_mem_read = mr;
      ex_rd       = rd;
      ex_redirect = redir;
      #2;
`ifdef HAZARD_PERF_CNT_EN
      check({name, " stall_cnt"}, stall_cnt, 16'(m_scnt));
      check({name, " flush_cnt"}, flush_cnt, 16'(m_fcnt));
`endif
      model_step(instr, v, mr, rd, redir, e);
      $display("cyc %s instr=%h v=%b mr=%b rd=%0d redir=%b -> out=%b model=%b",
               name, instr, v, mr, rd, redir, outs(), e);
      check({name, " model"}, 16'(outs()), 16'(e));
      if (use_lit) check({name, " literal"}, 16'(outs()), 16'(lit));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string name, input logic [4:0] lit);
      step(name, 16'hC000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, lit);
   endtask

   // Asynchronous reset from mid-cycle; outputs must drop before any edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("async_reset outs", 16'(outs()), 16'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("async_reset stall_cnt", stall_cnt, 16'd0);
      check("async_reset flush_cnt", flush_cnt, 16'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_halted = 1'b0; m_flush_rem = 0; m_drain_rem = 0; m_scnt = 0; m_fcnt = 0;
      $display("rst applied and released at %0t", $time);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int halted_for;
      logic [15:0] ri;
      logic [3:0]  rrd;
      rst_n = 1'b0; id_instr = 16'd0; id_valid = 1'b0;
      ex_mem_read = 1'b0; ex_rd = 4'd0; ex_redirect = 1'b1;
      #2;
      check("power_on_reset outs", 16'(outs()), 16'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
      // Three separate load-use stalls.
      for (int k = 0; k < 3; k++) begin
         step("perf_lu", 16'h0431, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 5'b11010);
         idle("perf_idle", 5'b00000);
      end
      check("perf stall_cnt==3", stall_cnt, 16'd3);
`endif

      // Load-use: LW R3 ahead of ADD R4,R3,R1.
      step("lu_add", 16'h0431, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 5'b11010);
      step("lu_after", 16'h0431, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 5'b00000);
      // R0 destination never hazards.
      step("lu_r0", 16'h0401, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 5'b00000);
      // SW data register [11:8]=5 behind LW R5.
      step("lu_sw", 16'h9520, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 5'b11010);
      idle("lu_sw_after", 5'b00000);
      // Bubble in ID does not hazard.
      step("lu_bubble", 16'h0431, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 5'b00000);

      // Single redirect: exactly two flush cycles.
      step("redir_1a", 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'b00110);
      step("redir_1b", 16'h0431, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 5'b00110);
      idle("redir_1c", 5'b00000);
      // Second redirect in cycle 2 extends the window to three cycles.
      step("redir_2a", 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'b00110);
      step("redir_2b", 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'b00110);
      step("redir_2c", 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 5'b00110);
      idle("redir_2d", 5'b00000);

      // 1111 other than HALT is a no-op.
      step("f000_nop", 16'hF000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 5'b00000);
      // HALT: drain, then halted three cycles later, sticky.
      step("halt_t0", 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 5'b10100);
      idle("halt_t1", 5'b10100);
      idle("halt_t2", 5'b10100);
      idle("halt_t3", 5'b10111);
      step("halt_t4", 16'h0431, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 5'b10111);
      do_reset();

      // HALT together with redirect: redirect wins, never halts.
      step("halt_redir_a", 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 5'b00110);
      idle("halt_redir_b", 5'b00110);
      idle("halt_redir_c", 5'b00000);
      idle("halt_redir_d", 5'b00000);
      idle("halt_redir_e", 5'b00000);

      // Reset in the middle of a drain.
      step("rst_drain_t0", 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 5'b10100);
      idle("rst_drain_t1", 5'b10100);
      do_reset();
      idle("rst_drain_p0", 5'b00000);
      idle("rst_drain_p1", 5'b00000);
      idle("rst_drain_p2", 5'b00000);
      idle("rst_drain_p3", 5'b00000);

      // Randomized traffic against the model.
      halted_for = 0;
      for (int n = 0; n < 3000; n++) begin
         if ((m_halted && halted_for > 4) || $urandom_range(0, 299) == 0) begin
            do_reset();
            halted_for = 0;
         end else begin
            ri  = ($urandom_range(0, 29) == 0) ? 16'hFFFF : 16'($urandom);
            rrd = ($urandom_range(0, 1) == 1) ? ri[7:4] : 4'($urandom);
            step("rand", ri, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                 rrd, $urandom_range(0, 7) == 0, 1'b0, 5'b00000);
            if (m_halted) halted_for++;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
